// File: rtl/alu_control_fsm_pkg.sv
// Shared types and constants for the 20-bit CPU control unit: opcodes, ALU
// encodings, FSM states, instruction classes and the immediate sign-extender.
package alu_control_fsm_pkg;

  localparam int DATA_W  = 20;
  localparam int IMM_W   = 8;
  localparam int RADDR_W = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BN   = 4'hA;
  localparam logic [3:0] OP_BP   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_BR   = 3'd4,
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } instr_class_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_control_fsm_if.sv
// Bundle of fetch, ALU, register-file and memory signals around the control unit.
// master: the control FSM; slave: the surrounding datapath.
interface alu_control_fsm_if;
  import alu_control_fsm_pkg::*;

  logic [DATA_W-1:0]  instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               ZeroFlag;
  logic               NegativeFlag;
  logic               PF;
  logic [2:0]         aluop;
  logic               alu_src_imm;
  logic [RADDR_W-1:0] rd_addr;
  logic [RADDR_W-1:0] rs1_addr;
  logic [RADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0]  imm_out;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_done;
  logic               pc_inc;
  logic               pc_load;
  logic [2:0]         flags;
  logic               illegal;
  logic               halted;

  modport master (
    input  instr, instr_valid, ZeroFlag, NegativeFlag, PF, mem_done,
    output instr_ready, aluop, alu_src_imm, rd_addr, rs1_addr, rs2_addr, imm_out,
           reg_write, mem_read, mem_write, pc_inc, pc_load, flags, illegal, halted
  );

  modport slave (
    output instr, instr_valid, ZeroFlag, NegativeFlag, PF, mem_done,
    input  instr_ready, aluop, alu_src_imm, rd_addr, rs1_addr, rs2_addr, imm_out,
           reg_write, mem_read, mem_write, pc_inc, pc_load, flags, illegal, halted
  );

endinterface

// File: rtl/alu_control_fsm_decoder.sv
// Combinational opcode decoder: ALU operation, operand-2 select and instruction class.
module alu_control_fsm_decoder
  import alu_control_fsm_pkg::*;
(
  input  logic [3:0]   opcode,
  output logic [2:0]   aluop,
  output logic         alu_src_imm,
  output instr_class_e cls
);

  // Opcode to control-field mapping; C-E fall through to illegal
  always_comb begin
    aluop       = ALU_ADD;
    alu_src_imm = 1'b0;
    cls         = CLS_ILL;
    case (opcode)
      OP_ADD:  begin aluop = ALU_ADD;  cls = CLS_ALU; end
      OP_SUB:  begin aluop = ALU_SUB;  cls = CLS_ALU; end
      OP_OR:   begin aluop = ALU_OR;   cls = CLS_ALU; end
      OP_NAND: begin aluop = ALU_NAND; cls = CLS_ALU; end
      OP_SHL:  begin aluop = ALU_SHL;  cls = CLS_ALU; end
      OP_ADDI: begin alu_src_imm = 1'b1; cls = CLS_ALU; end
      OP_LD:   begin alu_src_imm = 1'b1; cls = CLS_LD;  end
      OP_ST:   begin alu_src_imm = 1'b1; cls = CLS_ST;  end
      OP_JMP:  cls = CLS_JMP;
      OP_BZ, OP_BN, OP_BP: cls = CLS_BR;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/alu_control_fsm.sv
// Multi-cycle control FSM for the 20-bit ALU datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing with latched instruction fields and {Z,N,P} flags for branches.
module alu_control_fsm
  import alu_control_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_control_fsm_if.master bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [2:0]        flags_q, flags_d;

  logic [3:0]        opcode;
  logic [2:0]        dec_aluop;
  logic              dec_src_imm;
  instr_class_e      dec_class;
  logic              br_taken;

  assign opcode = instr_q[19:16];

  alu_control_fsm_decoder u_decoder (
    .opcode      (opcode),
    .aluop       (dec_aluop),
    .alu_src_imm (dec_src_imm),
    .cls         (dec_class)
  );

  // Branches test flags left by an earlier ALU instruction, never the current one
  assign br_taken = ((opcode == OP_BZ) && flags_q[2]) ||
                    ((opcode == OP_BN) && flags_q[1]) ||
                    ((opcode == OP_BP) && flags_q[0]);

  assign bus.rd_addr  = instr_q[15:12];
  assign bus.rs1_addr = instr_q[11:8];
  assign bus.rs2_addr = instr_q[7:4];
  assign bus.imm_out  = sext_imm(instr_q[7:0]);
  assign bus.flags    = flags_q;

  // State, latched instruction word and ALU flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      instr_q <= {DATA_W{1'b0}};
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    flags_d         = flags_q;
    bus.instr_ready = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.illegal     = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.halted      = 1'b0;
    bus.aluop       = ALU_ADD;
    bus.alu_src_imm = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d    = bus.instr;
          bus.pc_inc = 1'b1;
          state_d    = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_HALT: state_d = ST_HALT;
          CLS_ILL: begin
            bus.illegal = 1'b1;
            state_d     = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        bus.aluop       = dec_aluop;
        bus.alu_src_imm = dec_src_imm;
        case (dec_class)
          CLS_ALU: begin
            flags_d = {bus.ZeroFlag, bus.NegativeFlag, bus.PF};
            state_d = ST_WB;
          end
          CLS_LD, CLS_ST: state_d = ST_MEM;
          CLS_JMP: begin
            bus.pc_load = 1'b1;
            state_d     = ST_FETCH;
          end
          CLS_BR: begin
            bus.pc_load = br_taken;
            state_d     = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        bus.aluop       = dec_aluop;
        bus.alu_src_imm = dec_src_imm;
        bus.mem_read    = (dec_class == CLS_LD);
        bus.mem_write   = (dec_class == CLS_ST);
        if (bus.mem_done) begin
          state_d = (dec_class == CLS_LD) ? ST_WB : ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        bus.aluop       = dec_aluop;
        bus.alu_src_imm = dec_src_imm;
        bus.reg_write   = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        state_d    = ST_HALT;
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Randomized bench for alu_control_fsm: every instruction is scored cycle by cycle
// against a timeline derived from its opcode class, latched flags and memory latency.
module tb_alu_control_fsm;
  import alu_control_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] flags_m;

  always #5 clk = ~clk;

  alu_control_fsm_if bus ();

  alu_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {bus.instr_ready, bus.pc_inc, bus.pc_load, bus.illegal,
            bus.mem_read, bus.mem_write, bus.reg_write, bus.halted};
  endfunction

  task automatic check_idle_state(input string tag);
    check_eq({tag, " strobes"}, 32'(strobes()), 32'h80);
    check_eq({tag, " aluop"}, 32'({bus.aluop, bus.alu_src_imm}), 32'h0);
    check_eq({tag, " flags"}, 32'(bus.flags), 32'(flags_m));
  endtask

  task automatic reset_and_check();
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    flags_m = 3'b000;
    #1;
    check_idle_state("reset");
    check_eq("reset fields", 32'({bus.rd_addr, bus.rs1_addr, bus.rs2_addr}), 32'h0);
    check_eq("reset imm", 32'(bus.imm_out), 32'h0);
    #1 rst = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = DATA_W'($urandom);
    {bus.ZeroFlag, bus.NegativeFlag, bus.PF} = 3'($urandom);
    bus.mem_done = 1'($urandom_range(0, 1));
    #1;
    check_idle_state("idle");
  endtask

  // w = number of MEM cycles for LD/ST; abort_at >= 0 pulses rst in that cycle
  task automatic run_instr(input logic [3:0] op, input int w, input bit fix_znp,
                           input logic [2:0] znp_fix, input int abort_at);
    logic [DATA_W-1:0] ins;
    logic [2:0]  znp;
    logic [2:0]  fl_new;
    logic [7:0]  exp_s;
    logic [3:0]  exp_alu;
    logic [31:0] exp_imm;
    bit is_alu, is_ld, is_st, is_jmp, is_br, is_hlt, is_ill, taken, aborted;
    int len;
    string tg;
    ins    = {op, 16'($urandom)};
    is_alu = (op <= 4'h5);
    is_ld  = (op == 4'h6);
    is_st  = (op == 4'h7);
    is_jmp = (op == 4'h8);
    is_br  = (op >= 4'h9) && (op <= 4'hB);
    is_hlt = (op == 4'hF);
    is_ill = (op >= 4'hC) && (op <= 4'hE);
    taken  = is_jmp || ((op == 4'h9) && flags_m[2]) || ((op == 4'hA) && flags_m[1]) ||
             ((op == 4'hB) && flags_m[0]);
    len    = is_alu ? 4 : is_ld ? 4 + w : is_st ? 3 + w : is_ill ? 2 : is_hlt ? 5 : 3;
    fl_new = flags_m;
    aborted = 1'b0;
    exp_imm = ins[7] ? (32'(ins[7:0]) + 32'h000FFF00) : 32'(ins[7:0]);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      bus.instr_valid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.instr = (c == 0) ? ins : DATA_W'($urandom);
      znp = fix_znp ? znp_fix : 3'($urandom);
      {bus.ZeroFlag, bus.NegativeFlag, bus.PF} = znp;
      if ((is_ld || is_st) && (c >= 3)) bus.mem_done = (c == 2 + w);
      else bus.mem_done = 1'($urandom_range(0, 1));
      #1;
      tg = $sformatf("op%0h c%0d", op, c);
      exp_s = {c == 0, c == 0, (c == 2) && taken, (c == 1) && is_ill,
               is_ld && (c >= 3) && (c < 3 + w), is_st && (c >= 3) && (c < 3 + w),
               (is_alu && (c == 3)) || (is_ld && (c == 3 + w)), is_hlt && (c >= 2)};
      exp_alu = {((c >= 2) && (op <= 4'h4)) ? op[2:0] : 3'b000,
                 (c >= 2) && (op >= 4'h5) && (op <= 4'h7)};
      check_eq({tg, " strobes"}, 32'(strobes()), 32'(exp_s));
      check_eq({tg, " aluop"}, 32'({bus.aluop, bus.alu_src_imm}), 32'(exp_alu));
      check_eq({tg, " flags"}, 32'(bus.flags), 32'((is_alu && (c >= 3)) ? fl_new : flags_m));
      if (c == 1) begin
        check_eq({tg, " fields"}, 32'({bus.rd_addr, bus.rs1_addr, bus.rs2_addr}), 32'(ins[15:4]));
        check_eq({tg, " imm"}, 32'(bus.imm_out), exp_imm);
      end
      if ((c == 2) && is_alu) fl_new = znp;
      if (c == abort_at) begin
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        flags_m = 3'b000;
        aborted = 1'b1;
        #1;
        check_idle_state({tg, " abort"});
        #1 rst = 1'b0;
        break;
      end
    end
    if (!aborted && is_alu) flags_m = fl_new;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = {DATA_W{1'b0}};
    {bus.ZeroFlag, bus.NegativeFlag, bus.PF} = 3'b000;
    bus.mem_done = 1'b0;
    flags_m = 3'b000;
    repeat (2) @(posedge clk);
    reset_and_check();

    run_instr(4'h0, 1, 1'b1, 3'b101, -1);  // ADD with zero result
    run_instr(4'h1, 1, 1'b1, 3'b010, -1);  // SUB with negative result
    run_instr(4'hA, 1, 1'b0, 3'b000, -1);  // BN taken
    run_instr(4'h9, 1, 1'b0, 3'b000, -1);  // BZ not taken
    run_instr(4'h6, 3, 1'b0, 3'b000, -1);  // LD, 3 memory cycles
    run_instr(4'h7, 1, 1'b0, 3'b000, -1);  // ST, same-cycle done
    run_instr(4'hD, 1, 1'b0, 3'b000, -1);  // illegal
    idle_cycle();
    run_instr(4'h7, 4, 1'b0, 3'b000, 4);   // reset in the middle of ST's MEM
    run_instr(4'h4, 1, 1'b0, 3'b000, -1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      run_instr(4'($urandom_range(0, 14)), $urandom_range(1, 4), 1'b0, 3'b000, -1);
    end

    run_instr(4'hF, 1, 1'b0, 3'b000, -1);  // HALT, stays halted with valid toggling
    reset_and_check();
    run_instr(4'h2, 1, 1'b0, 3'b000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
